// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754-style add/sub (RNE, subnormals flushed); 3-cycle latency, one op per cycle.
// Backpressure: global stall, every stage holds while out_valid & !out_ready; in_ready = !out_valid | out_ready.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [EXP_W+MAN_W:0]       in_a,
   input  logic [EXP_W+MAN_W:0]       in_b,
   input  logic                       in_op,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [EXP_W+MAN_W:0]       out_s,
   output logic [TAG_W-1:0]           out_tag,
   output logic                       out_ovf,
   output logic                       out_zero,
   output logic                       out_inexact
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SIG = MAN_W + 1;
   localparam int F   = SIG + 3;
   localparam int LZW = $clog2(F + 1);
   localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------- S1: unpack / swap / align ----------------
   logic             a_sign, b_sign, a_zero, b_zero, a_max, b_max;
   logic             a_nan, b_nan, a_inf, b_inf, b_gt;
   logic [EXP_W-1:0] a_exp, b_exp, l_exp, s_exp, d;
   logic [MAN_W-1:0] a_man, b_man;
   logic [SIG-1:0]   a_sig, b_sig, l_sig, s_sig;
   logic             l_sign, s_sign;
   logic [F-1:0]     s_field, lost_mask, s_al;
   logic             sp;
   logic [W-1:0]     sp_val;

   always_comb begin
      a_sign    = in_a[W-1];
      b_sign    = in_b[W-1] ^ in_op;
      a_exp     = in_a[W-2:MAN_W];
      b_exp     = in_b[W-2:MAN_W];
      a_man     = in_a[MAN_W-1:0];
      b_man     = in_b[MAN_W-1:0];
      a_zero    = (a_exp == '0);
      b_zero    = (b_exp == '0);
      a_max     = &a_exp;
      b_max     = &b_exp;
      a_nan     = a_max && (a_man != '0);
      b_nan     = b_max && (b_man != '0);
      a_inf     = a_max && (a_man == '0);
      b_inf     = b_max && (b_man == '0);
      a_sig     = a_zero ? '0 : {1'b1, a_man};
      b_sig     = b_zero ? '0 : {1'b1, b_man};
      b_gt      = {b_exp, b_sig} > {a_exp, a_sig};
      l_sign    = b_gt ? b_sign : a_sign;
      s_sign    = b_gt ? a_sign : b_sign;
      l_exp     = b_gt ? b_exp  : a_exp;
      s_exp     = b_gt ? a_exp  : b_exp;
      l_sig     = b_gt ? b_sig  : a_sig;
      s_sig     = b_gt ? a_sig  : b_sig;
      d         = l_exp - s_exp;
      s_field   = {s_sig, 3'b000};
      // Shifts past the field width leave every bit in lost_mask, i.e. sticky only.
      lost_mask = ~({F{1'b1}} << d);
      s_al      = (s_field >> d) | {{(F-1){1'b0}}, |(s_field & lost_mask)};
      sp        = a_nan || b_nan || a_inf || b_inf;
      if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
         sp_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (a_inf)
         sp_val = {a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
         sp_val = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   end

   logic             s1_vld, s1_sign, s1_sub, s1_sp;
   logic [EXP_W-1:0] s1_exp;
   logic [SIG-1:0]   s1_sig;
   logic [F-1:0]     s1_al;
   logic [W-1:0]     s1_sp_val;
   logic [TAG_W-1:0] s1_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         s1_sign   <= 1'b0;
         s1_sub    <= 1'b0;
         s1_sp     <= 1'b0;
         s1_exp    <= '0;
         s1_sig    <= '0;
         s1_al     <= '0;
         s1_sp_val <= '0;
         s1_tag    <= '0;
      end else if (adv) begin
         s1_vld    <= in_valid;
         s1_sign   <= l_sign;
         s1_sub    <= (l_sign != s_sign);
         s1_sp     <= sp;
         s1_exp    <= l_exp;
         s1_sig    <= l_sig;
         s1_al     <= s_al;
         s1_sp_val <= sp_val;
         s1_tag    <= in_tag;
      end
   end

   // ---------------- S2: add / subtract / normalise ----------------
   logic [F:0]     ext_l, ext_s, sum;
   logic [LZW-1:0] lz;
   logic [F-1:0]   norm;
   logic [EW-1:0]  nexp;
   logic           sum_zero;

   always_comb begin
      ext_l    = {1'b0, s1_sig, 3'b000};
      ext_s    = {1'b0, s1_al};
      sum      = s1_sub ? (ext_l - ext_s) : (ext_l + ext_s);
      sum_zero = (sum == '0);
      lz       = LZW'(F);
      for (int i = 0; i < F; i++)
         if (sum[i]) lz = LZW'(F - 1 - i);
      if (!s1_sub && sum[F]) begin
         norm = sum[F:1] | {{(F-1){1'b0}}, sum[0]};
         nexp = EW'(s1_exp) + EW'(1);
      end else begin
         norm = sum[F-1:0] << lz;
         nexp = EW'(s1_exp) - EW'(lz);
      end
   end

   logic             s2_vld, s2_sign, s2_zero, s2_sp;
   logic [EW-1:0]    s2_exp;
   logic [F-1:0]     s2_norm;
   logic [W-1:0]     s2_sp_val;
   logic [TAG_W-1:0] s2_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld    <= 1'b0;
         s2_sign   <= 1'b0;
         s2_zero   <= 1'b0;
         s2_sp     <= 1'b0;
         s2_exp    <= '0;
         s2_norm   <= '0;
         s2_sp_val <= '0;
         s2_tag    <= '0;
      end else if (adv) begin
         s2_vld    <= s1_vld;
         // Exact cancellation gives +0; a true zero sum keeps the sign of L.
         s2_sign   <= (sum_zero && s1_sub) ? 1'b0 : s1_sign;
         s2_zero   <= sum_zero;
         s2_sp     <= s1_sp;
         s2_exp    <= nexp;
         s2_norm   <= norm;
         s2_sp_val <= s1_sp_val;
         s2_tag    <= s1_tag;
      end
   end

   // ---------------- S3: round / pack / flags ----------------
   logic [SIG-1:0] mant;
   logic [SIG:0]   mant_r;
   logic           rnd_g, rnd_r, rnd_s, rnd_inex, rnd_up;
   logic [EW-1:0]  e_r, emax;
   logic [W-1:0]   res;
   logic           res_ovf, res_zero, res_inex;

   always_comb begin
      mant     = s2_norm[F-1:3];
      rnd_g    = s2_norm[2];
      rnd_r    = s2_norm[1];
      rnd_s    = s2_norm[0];
      rnd_inex = rnd_g || rnd_r || rnd_s;
      rnd_up   = rnd_g && (rnd_r || rnd_s || mant[0]);
      mant_r   = {1'b0, mant} + (SIG+1)'(rnd_up);
      e_r      = s2_exp + EW'(mant_r[SIG]);
      emax     = EW'({EXP_W{1'b1}});
      res      = {s2_sign, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
      res_ovf  = 1'b0;
      res_zero = 1'b0;
      res_inex = rnd_inex;
      if (s2_sp) begin
         res      = s2_sp_val;
         res_inex = 1'b0;
      end else if (s2_zero) begin
         res      = {s2_sign, {(W-1){1'b0}}};
         res_zero = 1'b1;
         res_inex = 1'b0;
      end else if (!e_r[EW-1] && (e_r >= emax)) begin
         res      = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         res_ovf  = 1'b1;
         res_inex = 1'b1;
      end else if (e_r[EW-1] || (e_r == '0)) begin
         res      = {s2_sign, {(W-1){1'b0}}};
         res_zero = 1'b1;
         res_inex = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_s       <= '0;
         out_tag     <= '0;
         out_ovf     <= 1'b0;
         out_zero    <= 1'b0;
         out_inexact <= 1'b0;
      end else if (adv) begin
         out_valid   <= s2_vld;
         out_s       <= res;
         out_tag     <= s2_tag;
         out_ovf     <= res_ovf;
         out_zero    <= res_zero;
         out_inexact <= res_inex;
      end
   end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: FP32 and 16-bit instances, directed vectors, scoreboard queues, stall and reset cases.
module tb_fp_add_pipe;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] s;
      logic        ovf;
      logic        zero;
      logic        inex;
   } vec_t;

   typedef struct packed {
      logic [31:0] s;
      logic [3:0]  tag;
      logic        ovf;
      logic        zero;
      logic        inex;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, in_op, out_valid, out_ready;
   logic [31:0] in_a, in_b, out_s;
   logic [3:0]  in_tag, out_tag;
   logic        out_ovf, out_zero, out_inexact;

   logic        h_in_valid, h_in_ready, h_in_op, h_out_valid, h_out_ready;
   logic [15:0] h_in_a, h_in_b, h_out_s;
   logic [3:0]  h_in_tag, h_out_tag;
   logic        h_out_ovf, h_out_zero, h_out_inexact;

   vec_t tv [18];
   vec_t hv [7];
   exp_t q  [$];
   exp_t q2 [$];
   exp_t mon_e, mon_e2;
   int   cur, cur2;
   int   checks, errors;

   fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_tag(out_tag),
      .out_ovf(out_ovf), .out_zero(out_zero), .out_inexact(out_inexact)
   );

   fp_add_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
      .clk(clk), .rst_n(rst_n),
      .in_valid(h_in_valid), .in_ready(h_in_ready), .in_a(h_in_a), .in_b(h_in_b),
      .in_op(h_in_op), .in_tag(h_in_tag),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .out_s(h_out_s), .out_tag(h_out_tag),
      .out_ovf(h_out_ovf), .out_zero(h_out_zero), .out_inexact(h_out_inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, got, want);
      end
   endtask

   // Scoreboards: push on input transfer, pop and compare on output transfer.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_out32", 32'(out_valid), 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("s32",     out_s,               mon_e.s);
            chk("tag32",   32'(out_tag),        32'(mon_e.tag));
            chk("ovf32",   32'(out_ovf),        32'(mon_e.ovf));
            chk("zero32",  32'(out_zero),       32'(mon_e.zero));
            chk("inex32",  32'(out_inexact),    32'(mon_e.inex));
         end
      end
      if (rst_n && in_valid && in_ready)
         q.push_back('{tv[cur].s, in_tag, tv[cur].ovf, tv[cur].zero, tv[cur].inex});
   end

   always @(negedge clk) begin
      if (rst_n && h_out_valid && h_out_ready) begin
         if (q2.size() == 0) begin
            chk("spurious_out16", 32'(h_out_valid), 32'd0);
         end else begin
            mon_e2 = q2.pop_front();
            chk("s16",    32'(h_out_s),       mon_e2.s);
            chk("tag16",  32'(h_out_tag),     32'(mon_e2.tag));
            chk("ovf16",  32'(h_out_ovf),     32'(mon_e2.ovf));
            chk("zero16", 32'(h_out_zero),    32'(mon_e2.zero));
            chk("inex16", 32'(h_out_inexact), 32'(mon_e2.inex));
         end
      end
      if (rst_n && h_in_valid && h_in_ready)
         q2.push_back('{hv[cur2].s, h_in_tag, hv[cur2].ovf, hv[cur2].zero, hv[cur2].inex});
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send32(input int idx, input logic [3:0] tag);
      int n;
      cur = idx; in_a = tv[idx].a; in_b = tv[idx].b; in_op = tv[idx].op; in_tag = tag;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_timeout32", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send16(input int idx, input logic [3:0] tag);
      int n;
      cur2 = idx; h_in_a = hv[idx].a[15:0]; h_in_b = hv[idx].b[15:0];
      h_in_op = hv[idx].op; h_in_tag = tag;
      h_in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!h_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_timeout16", 32'(h_in_ready), 32'd1);
      @(posedge clk); #1;
      h_in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || q2.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", 32'(q.size() + q2.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc, held_ok;
      logic [31:0] held_s;
      logic [3:0]  held_tag;
      int          idx;

      checks = 0; errors = 0; cur = 0; cur2 = 0;
      tv[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0};
      tv[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0};
      tv[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
      tv[3]  = '{32'hC0000000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
      tv[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
      tv[5]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b1};
      tv[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
      tv[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0};
      tv[8]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0};
      tv[9]  = '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b0};
      tv[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0};
      tv[11] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1'b0};
      tv[12] = '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1};
      tv[13] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 1'b1, 1'b0, 1'b1};
      tv[14] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      tv[15] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1};
      tv[16] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0};
      tv[17] = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1'b0};
      hv[0]  = '{32'h3C00, 32'h3C00, 1'b0, 32'h4000, 1'b0, 1'b0, 1'b0};
      hv[1]  = '{32'h4200, 32'h3C00, 1'b1, 32'h4000, 1'b0, 1'b0, 1'b0};
      hv[2]  = '{32'h3C00, 32'h3C00, 1'b1, 32'h0000, 1'b0, 1'b1, 1'b0};
      hv[3]  = '{32'h3C00, 32'h1000, 1'b0, 32'h3C00, 1'b0, 1'b0, 1'b1};
      hv[4]  = '{32'h3C00, 32'h1001, 1'b0, 32'h3C01, 1'b0, 1'b0, 1'b1};
      hv[5]  = '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 1'b1, 1'b0, 1'b1};
      hv[6]  = '{32'h7C00, 32'hFC00, 1'b0, 32'h7E00, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0; out_ready = 1'b1;
      h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_op = 1'b0; h_in_tag = '0; h_out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 32'(out_valid),   32'd0);
      chk("rst_out_s",     out_s,            32'd0);
      chk("rst_out_tag",   32'(out_tag),     32'd0);
      chk("rst_ovf",       32'(out_ovf),     32'd0);
      chk("rst_zero",      32'(out_zero),    32'd0);
      chk("rst_inex",      32'(out_inexact), 32'd0);
      chk("rst_in_ready",  32'(in_ready),    32'd1);
      chk("rst_h_valid",   32'(h_out_valid), 32'd0);
      chk("rst_h_ready",   32'(h_in_ready),  32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: out_valid rises on the third edge counting the accepting edge.
      send32(0, 4'h1);
      chk("lat32_e1", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat32_e2", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat32_e3", 32'(out_valid), 32'd1);
      for (int i = 1; i < 18; i++) send32(i, 4'(i));
      wait_drain();

      // Backpressure: 8 back-to-back ops, out_ready low for cycles 4..8.
      acc = 1'b0; held_ok = 1'b0; held_s = '0; held_tag = '0; idx = 0;
      for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
         if (acc) idx++;
         out_ready = !(cyc >= 4 && cyc <= 8);
         if (idx < 8) begin
            cur = idx; in_a = tv[idx].a; in_b = tv[idx].b; in_op = tv[idx].op;
            in_tag = 4'(idx); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (held_ok) begin
               chk("stall_hold_s",   out_s,         held_s);
               chk("stall_hold_tag", 32'(out_tag),  32'(held_tag));
            end
            held_s = out_s; held_tag = out_tag; held_ok = 1'b1;
         end else begin
            held_ok = 1'b0;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_accepted", 32'(idx), 32'd8);
      wait_drain();

      // Reset with three operations in flight.
      send32(4, 4'hA);
      send32(5, 4'hB);
      send32(6, 4'hC);
      chk("mid_valid_before_rst", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_s",     out_s,          32'd0);
      q.delete();
      q2.delete();
      @(posedge clk);
      @(posedge clk); #3;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("post_rst_idle", 32'(out_valid), 32'd0);
      end
      send32(16, 4'hD);
      wait_drain();

      // Half-width instance.
      send16(0, 4'h2);
      chk("lat16_e1", 32'(h_out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat16_e2", 32'(h_out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat16_e3", 32'(h_out_valid), 32'd1);
      for (int i = 1; i < 7; i++) send16(i, 4'(i + 8));
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
